// File: rtl/rr_receiver.sv
// Round-robin NoC input receiver: merges PORTS_NUM+1 channels into one FIFO write port.
// Optional wormhole packet locking is enabled by defining RR_RECV_PKT_LOCK_EN.
module rr_receiver #(
   parameter int unsigned DATA_SIZE = 4,
   parameter int unsigned ADDR_SIZE = 1,
   parameter int unsigned PORTS_NUM = 4
) (
   input  logic                                        clk,
   input  logic                                        a_rst,
   input  logic                                        is_full,
   input  logic [PORTS_NUM:0]                          in_r,
   input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0] data_i,
   output logic                                        wr_req,
   output logic [PORTS_NUM:0]                          in_w,
   output logic [DATA_SIZE+ADDR_SIZE:0]                data_o,
   output logic                                        busy
);

   localparam int unsigned W   = DATA_SIZE + ADDR_SIZE + 1;
   localparam int unsigned NCH = PORTS_NUM + 1;
   localparam int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      LOCK = 2'd2
   } state_e;

   state_e          state_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   lock_q;
   logic            wr_req_q;
   logic [NCH-1:0]  in_w_q;
   logic [W-1:0]    data_o_q;
   logic            busy_q;

   logic [W-1:0]    flit_c [NCH];
   logic            rr_vld_c;
   logic [PW-1:0]   rr_idx_c;
   logic [PW-1:0]   idx_c;
   logic            sel_vld_c;
   logic [PW-1:0]   sel_idx_c;
   logic            acc_c;

   for (genvar k = 0; k < NCH; k++) begin : g_slice
      assign flit_c[k] = data_i[k*W +: W];
   end

   // Rotating search from ptr+1; scanning backwards leaves the nearest requester as winner.
   always_comb begin
      rr_vld_c = 1'b0;
      rr_idx_c = '0;
      idx_c    = '0;
      for (int i = int'(NCH); i >= 1; i--) begin
         idx_c = PW'((int'(ptr_q) + i) % int'(NCH));
         if (in_r[idx_c]) begin
            rr_vld_c = 1'b1;
            rr_idx_c = idx_c;
         end
      end
   end

   always_comb begin
      sel_vld_c = 1'b0;
      sel_idx_c = '0;
      case (state_q)
         IDLE: begin
            sel_vld_c = rr_vld_c;
            sel_idx_c = rr_idx_c;
         end
         LOCK: begin
            sel_vld_c = in_r[lock_q];
            sel_idx_c = lock_q;
         end
         default: begin
            sel_vld_c = 1'b0;
            sel_idx_c = '0;
         end
      endcase
      acc_c = sel_vld_c && !is_full;
   end

   // Accept in IDLE/LOCK, then one ACK cycle so the sender can retire the flit.
   always_ff @(posedge clk) begin
      if (a_rst) begin
         state_q  <= IDLE;
         ptr_q    <= PW'(PORTS_NUM);
         lock_q   <= '0;
         wr_req_q <= 1'b0;
         in_w_q   <= '0;
         data_o_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         wr_req_q <= 1'b0;
         in_w_q   <= '0;
         case (state_q)
            IDLE, LOCK: begin
               if (acc_c) begin
                  wr_req_q <= 1'b1;
                  in_w_q   <= NCH'(1'b1) << sel_idx_c;
                  data_o_q <= flit_c[sel_idx_c];
                  state_q  <= ACK;
                  busy_q   <= 1'b1;
                  if (state_q == IDLE) begin
                     ptr_q  <= sel_idx_c;
                     lock_q <= sel_idx_c;
                  end
               end
            end
            ACK: begin
`ifdef RR_RECV_PKT_LOCK_EN
               if (!data_o_q[W-1]) begin
                  state_q <= LOCK;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
`else
               state_q <= IDLE;
               busy_q  <= 1'b0;
`endif
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_req = wr_req_q;
   assign in_w   = in_w_q;
   assign data_o = data_o_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_rr_receiver.sv
// Scoreboard bench for rr_receiver: per-channel sender queues, expected writes queued by stimulus.
module tb_rr_receiver;

   localparam int unsigned W   = 6;
   localparam int unsigned NCH = 5;

   logic              clk = 1'b0;
   logic              a_rst;
   logic              is_full;
   logic [NCH-1:0]    in_r = '0;
   logic [W*NCH-1:0]  data_i = '0;
   logic              wr_req;
   logic [NCH-1:0]    in_w;
   logic [W-1:0]      data_o;
   logic              busy;

   logic [W-1:0]       chq [NCH][$];
   logic [NCH+W-1:0]   exp_q [$];
   int                 n_chk  = 0;
   int                 n_fail = 0;
   bit                 mon_en = 1'b0;

   rr_receiver #(.DATA_SIZE(4), .ADDR_SIZE(1), .PORTS_NUM(4)) dut (
      .clk     (clk),
      .a_rst   (a_rst),
      .is_full (is_full),
      .in_r    (in_r),
      .data_i  (data_i),
      .wr_req  (wr_req),
      .in_w    (in_w),
      .data_o  (data_o),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Sender model: retire the head flit when acked, present the next one.
   always @(negedge clk) begin
      for (int k = 0; k < int'(NCH); k++) begin
         if (in_w[k] === 1'b1 && chq[k].size() > 0) void'(chq[k].pop_front());
      end
      for (int k = 0; k < int'(NCH); k++) begin
         in_r[k] = (chq[k].size() > 0);
         data_i[k*W +: W] = (chq[k].size() > 0) ? chq[k][0] : '0;
      end
   end

   // Monitor: every FIFO write is matched against the next expected entry.
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_req === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_write: got in_w=%b data_o=%h expected no write", in_w, data_o);
            end else begin
               logic [NCH+W-1:0] e;
               e = exp_q.pop_front();
               chk("wr_in_w", 32'(in_w), 32'(e[NCH+W-1:W]));
               chk("wr_data_o", 32'(data_o), 32'(e[W-1:0]));
               chk("wr_onehot", 32'($onehot(in_w)), 32'd1);
            end
         end else begin
            chk("nowr_in_w", 32'(in_w), 32'd0);
         end
      end
   end

   task automatic send(input int ch, input logic [W-1:0] flit);
      chq[ch].push_back(flit);
   endtask

   task automatic expect_wr(input int ch, input logic [W-1:0] flit);
      logic [NCH-1:0] oh;
      oh = NCH'(1) << ch;
      exp_q.push_back({oh, flit});
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || chq[0].size() != 0 || chq[1].size() != 0 ||
              chq[2].size() != 0 || chq[3].size() != 0 || chq[4].size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_wr_req"}, 32'(wr_req), 32'd0);
      chk({nm, "_in_w"}, 32'(in_w), 32'd0);
   endtask

   initial begin
      a_rst   = 1'b1;
      is_full = 1'b0;

      // Reset with all channels requesting, then fairness sweep 0,1,2,3,4,0.
      send(0, 6'h20); send(1, 6'h21); send(2, 6'h22); send(3, 6'h23); send(4, 6'h24);
      send(0, 6'h2A);
      expect_wr(0, 6'h20); expect_wr(1, 6'h21); expect_wr(2, 6'h22);
      expect_wr(3, 6'h23); expect_wr(4, 6'h24); expect_wr(0, 6'h2A);
      repeat (2) begin
         @(posedge clk); #1;
         chk_quiet("rst");
         chk("rst_data_o", 32'(data_o), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      a_rst  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk_quiet("rel");
      chk("rel_busy", 32'(busy), 32'd0);
      drain(100);

      // Single request with one-cycle latency and one-cycle pulse.
      send(2, 6'b101010);
      expect_wr(2, 6'b101010);
      @(negedge clk);
      @(posedge clk); #1;
      chk("single_wr_req", 32'(wr_req), 32'd1);
      chk("single_in_w", 32'(in_w), 32'b00100);
      chk("single_data_o", 32'(data_o), 32'b101010);
      chk("single_busy_ack", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk_quiet("single_after");
      chk("single_data_hold", 32'(data_o), 32'b101010);
      drain(50);

      // Backpressure: nothing written while full, write one cycle after release.
      is_full = 1'b1;
      send(0, 6'h31);
      expect_wr(0, 6'h31);
      @(negedge clk);
      repeat (5) begin
         @(posedge clk); #1;
         chk_quiet("full");
      end
      is_full = 1'b0;
      @(posedge clk); #1;
      chk("bp_wr_req", 32'(wr_req), 32'd1);
      chk("bp_in_w", 32'(in_w), 32'b00001);
      drain(50);

      // Packet lock: ch1 head (tail=0) with ch3 competing, then ch1 tail.
      send(1, 6'h05); send(3, 6'h33); send(1, 6'h27);
      expect_wr(1, 6'h05);
`ifdef RR_RECV_PKT_LOCK_EN
      expect_wr(1, 6'h27); expect_wr(3, 6'h33);
`else
      expect_wr(3, 6'h33); expect_wr(1, 6'h27);
`endif
      @(negedge clk);
      @(posedge clk); #1;
      chk("lock_first_wr", 32'(wr_req), 32'd1);
      chk("lock_busy_ack", 32'(busy), 32'd1);
      @(posedge clk); #1;
`ifdef RR_RECV_PKT_LOCK_EN
      chk("lock_busy_between", 32'(busy), 32'd1);
`else
      chk("lock_busy_between", 32'(busy), 32'd0);
`endif
      drain(100);

      // Reset mid-packet drops the lock and restores channel 0 priority.
      send(2, 6'h02);
      expect_wr(2, 6'h02);
      @(negedge clk);
      @(posedge clk); #1;
      chk("mid_head_wr", 32'(wr_req), 32'd1);
      a_rst = 1'b1;
      @(posedge clk); #1;
      a_rst = 1'b0;
      chk_quiet("mid_rst");
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_data_o", 32'(data_o), 32'd0);
      send(0, 6'h30); send(3, 6'h3B);
      expect_wr(0, 6'h30); expect_wr(3, 6'h3B);
      drain(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
